// File: rtl/da_column_mac.sv
// Bit-serial distributed-arithmetic MAC for one 7-pixel kernel column.
// A latched column is walked MSB-first one bit-plane per cycle. Each plane
// indexes two 4-input weight LUTs whose sum is shift-accumulated into the
// dot product, which is then held on a valid/ready output.
module da_column_mac #(
    parameter int PIX_W      = 8,
    parameter int KERNEL_H   = 7,   // only 7 is supported
    parameter int ACC_W      = 16,
    parameter int SIGNED_PIX = 0,
    parameter logic signed [4:0] WEIGHT_0 = 5'sd1,
    parameter logic signed [4:0] WEIGHT_1 = -5'sd2,
    parameter logic signed [4:0] WEIGHT_2 = 5'sd3,
    parameter logic signed [4:0] WEIGHT_3 = -5'sd4,
    parameter logic signed [4:0] WEIGHT_4 = 5'sd5,
    parameter logic signed [4:0] WEIGHT_5 = -5'sd6,
    parameter logic signed [4:0] WEIGHT_6 = 5'sd7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [KERNEL_H*PIX_W-1:0] pix_flat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          result
);

    localparam int CNT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PIX_W - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                      state_q, state_d;
    logic [KERNEL_H*PIX_W-1:0]   pix_q, pix_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [ACC_W-1:0]     result_q, result_d;
    logic                        out_valid_q, out_valid_d;

    logic [6:0]                  plane;
    logic signed [ACC_W-1:0]     lut_lo, lut_hi, lut_sum;

    // Signed sum of the weights selected by a 4-bit slice of the bit-plane;
    // this is the contents of one 16-entry DA lookup table.
    function automatic logic signed [ACC_W-1:0] lut4(
        input logic [3:0]        sel,
        input logic signed [4:0] w0,
        input logic signed [4:0] w1,
        input logic signed [4:0] w2,
        input logic signed [4:0] w3
    );
        logic signed [ACC_W-1:0] s;
        s = '0;
        if (sel[0]) s = s + ACC_W'(w0);
        if (sel[1]) s = s + ACC_W'(w1);
        if (sel[2]) s = s + ACC_W'(w2);
        if (sel[3]) s = s + ACC_W'(w3);
        return s;
    endfunction

    // Current bit-plane and its two-group LUT lookup (group 0 padded with a zero weight).
    always_comb begin
        plane = '0;
        for (int j = 0; j < 7; j++) begin
            plane[j] = pix_q[j*PIX_W + int'(cnt_q)];
        end
        lut_lo  = lut4({1'b0, plane[2:0]}, WEIGHT_0, WEIGHT_1, WEIGHT_2, 5'sd0);
        lut_hi  = lut4(plane[6:3], WEIGHT_3, WEIGHT_4, WEIGHT_5, WEIGHT_6);
        lut_sum = lut_lo + lut_hi;
    end

    // Next-state and datapath: accept, shift-accumulate planes, hold result.
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pix_d   = pix_flat;
                    cnt_d   = CNT_TOP;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The MSB plane carries negative weight for two's-complement pixels.
                if (cnt_q == CNT_TOP) begin
                    acc_d = (SIGNED_PIX != 0) ? -lut_sum : lut_sum;
                end else begin
                    acc_d = (acc_q <<< 1) + lut_sum;
                end
                if (cnt_q == '0) begin
                    result_d    = acc_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any column in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_da_column_mac.sv
// Scoreboard bench for da_column_mac: an unsigned and a signed-pixel instance
// see identical stimulus; expected dot products are queued at each accept and
// popped by a monitor on every output handshake.
module tb_da_column_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [55:0] pix_flat = '0;
    logic        in_ready_u, out_valid_u, in_ready_s, out_valid_s;
    logic [15:0] result_u, result_s;

    da_column_mac dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .pix_flat(pix_flat), .out_valid(out_valid_u), .out_ready(out_ready),
        .result(result_u)
    );

    da_column_mac #(.SIGNED_PIX(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .pix_flat(pix_flat), .out_valid(out_valid_s), .out_ready(out_ready),
        .result(result_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] q_u[$];
    logic [15:0] q_s[$];
    int W[7] = '{1, -2, 3, -4, 5, -6, 7};

    // Reference dot product: plain integer weighted sum, wrapped to 16 bits.
    function automatic logic [15:0] ref_dot(input logic [55:0] p, input bit sgn);
        int s;
        int v;
        s = 0;
        for (int i = 0; i < 7; i++) begin
            if (sgn) v = int'($signed(p[i*8 +: 8]));
            else     v = int'(p[i*8 +: 8]);
            s += W[i] * v;
        end
        return 16'(s);
    endfunction

    // Positive-weight pixels (0,2,4,6) get pos, negative-weight ones get neg.
    function automatic logic [55:0] fill(input logic [7:0] pos, input logic [7:0] neg);
        logic [55:0] f;
        for (int i = 0; i < 7; i++) f[i*8 +: 8] = (i % 2 == 0) ? pos : neg;
        return f;
    endfunction

    function automatic logic [55:0] rnd_pix();
        return 56'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Monitor: every output handshake pops and checks one expected result.
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (out_valid_u) begin
                if (q_u.size() == 0) fail_now("unexpected output (unsigned)");
                else chk("result_u", {16'h0, result_u}, {16'h0, q_u.pop_front()});
            end
            if (out_valid_s) begin
                if (q_s.size() == 0) fail_now("unexpected output (signed)");
                else chk("result_s", {16'h0, result_s}, {16'h0, q_s.pop_front()});
            end
        end
    end

    // Present a column and wait (bounded) for it to be accepted; in_valid stays high.
    task automatic send(input logic [55:0] p, input logic [15:0] eu, input logic [15:0] es,
                        output int acc_at);
        bit ok;
        ok       = 1'b0;
        acc_at   = cyc;
        in_valid = 1'b1;
        pix_flat = p;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready_u) begin
                q_u.push_back(eu);
                q_s.push_back(es);
                @(posedge clk);
                #1;
                acc_at = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("accept timeout");
    endtask

    task automatic send_rand(output int acc_at);
        logic [55:0] p;
        p = rnd_pix();
        send(p, ref_dot(p, 1'b0), ref_dot(p, 1'b1), acc_at);
    endtask

    // Wait (bounded) for out_valid and return cycles since the accept edge.
    task automatic wait_valid(input int acc_at, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid_u) begin
                lat = cyc - acc_at;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("out_valid timeout");
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            if (q_u.size() == 0 && q_s.size() == 0) break;
        end
        #1;
        chk("drain_u", q_u.size(), 0);
        chk("drain_s", q_s.size(), 0);
    endtask

    logic [55:0] dir_pix[7];
    int          dir_u[7] = '{1020, -1530, 4080, -3060, 512, 524, 255};
    int          dir_s[7] = '{-4, 6, -16, 12, -512, -3572, -1};
    bit          rand_done;

    initial begin
        int acc_at;
        int lat;
        int prev;
        logic [15:0] held;

        dir_pix[0] = fill(8'hFF, 8'hFF);
        dir_pix[1] = 56'h00_FF00_0000_0000;
        dir_pix[2] = fill(8'hFF, 8'h00);
        dir_pix[3] = fill(8'h00, 8'hFF);
        dir_pix[4] = fill(8'h80, 8'h80);
        dir_pix[5] = fill(8'h80, 8'h7F);
        dir_pix[6] = 56'h00_0000_0000_00FF;

        // Reset state
        #1;
        chk("rst in_ready", in_ready_u, 1);
        chk("rst out_valid", out_valid_u, 0);
        chk("rst result_u", result_u, 0);
        chk("rst result_s", result_s, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed columns with fixed expectations and latency check
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(dir_pix[i], 16'(dir_u[i]), 16'(dir_s[i]), acc_at);
            in_valid = 1'b0;
            wait_valid(acc_at, lat);
            chk("latency", lat, 8);
            drain();
        end

        // Backpressure: result held, new input ignored
        out_ready = 1'b0;
        send_rand(acc_at);
        in_valid = 1'b0;
        wait_valid(acc_at, lat);
        held = result_u;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            pix_flat = rnd_pix();
            @(negedge clk);
            chk("bp result", result_u, held);
            chk("bp out_valid", out_valid_u, 1);
            chk("bp in_ready", in_ready_u, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post-hs out_valid", out_valid_u, 0);
        chk("post-hs in_ready", in_ready_u, 1);
        drain();

        // Steady-state period with out_ready high
        out_ready = 1'b1;
        send_rand(prev);
        for (int i = 0; i < 5; i++) begin
            send_rand(acc_at);
            chk("period", acc_at - prev, 10);
            prev = acc_at;
        end
        in_valid = 1'b0;
        drain();

        // Back-to-back random columns with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 50; i++) send_rand(acc_at);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        in_valid = 1'b0;
        drain();

        // Reset during RUN discards the column
        out_ready = 1'b1;
        send_rand(acc_at);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", out_valid_u, 0);
        chk("mid-rst result_u", result_u, 0);
        chk("mid-rst result_s", result_s, 0);
        chk("mid-rst in_ready", in_ready_u, 1);
        q_u.delete();
        q_s.delete();
        repeat (10) begin
            @(negedge clk);
            chk("in-rst out_valid", out_valid_u | out_valid_s, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(dir_pix[5], 16'(dir_u[5]), 16'(dir_s[5]), acc_at);
        in_valid = 1'b0;
        wait_valid(acc_at, lat);
        chk("post-rst latency", lat, 8);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/da_column_mac.md
# da_column_mac

Bit-serial distributed-arithmetic multiply-accumulate engine for one vertical kernel column. It accepts a column of KERNEL_H pixels over a valid/ready handshake and feeds them MSB-first as bit-planes into an internal 7-input signed-weight lookup sum. The per-plane partial sums are shift-accumulated into a full-precision dot product, which is presented on a valid/ready output. It sits between the line-buffer column fetch and the horizontal pass of the separable convolution.

## Interface

Parameters:
- PIX_W, 8: pixel width in bits; equals the number of RUN cycles.
- KERNEL_H, 7: column height; only 7 is supported.
- ACC_W, 16: accumulator and result width in bits, signed.
- SIGNED_PIX, 0: 0 means pixels are unsigned; 1 means pixels are two's complement.
- WEIGHT_0..WEIGHT_6, 1, -2, 3, -4, 5, -6, 7: 5-bit signed compile-time weights for pixels 0..6.

Ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: pix_flat holds a valid column.
- in_ready, output, 1: the block can accept a column.
- pix_flat, input, KERNEL_H*PIX_W: pixel i occupies bits [i*PIX_W +: PIX_W].
- out_valid, output, 1: result holds a valid dot product.
- out_ready, input, 1: the downstream consumer accepts result.
- result, output, ACC_W: signed value sum(WEIGHT_i * pixel_i).

## Operation

- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch pix_flat into the pixel register, load the bit counter with PIX_W-1, go to RUN.
  - pix_flat is sampled only on the accept edge.
- RUN:
  - Each cycle, bit-plane b is formed: bit j = pixel_j[b], where b = the bit counter value.
  - The lookup sum is the signed sum of WEIGHT_j over all set bits j.
  - It is computed as two 4-entry-group LUTs: pixels {2,1,0 plus a zero pad} and pixels {6,5,4,3}, summed.
  - The lookup sum range is -12..16 with default weights, so it must be at least 6 bits signed. It is sign-extended to ACC_W.
- Accumulation:
  - First plane (b = PIX_W-1): acc = +lut when SIGNED_PIX=0; acc = -lut when SIGNED_PIX=1 (negative MSB weight).
  - Later planes: acc = (acc <<< 1) + lut.
  - All arithmetic is modulo 2^ACC_W; overflow is not flagged.
  - The default ACC_W=16 covers the full range of the default weights (-3572..4080).
- End of RUN: after plane 0, copy acc to result, set out_valid, go to DONE.
- DONE:
  - result is held stable and out_valid = 1.
  - On out_ready: clear out_valid, go to IDLE.
  - in_valid is ignored while in RUN or DONE (in_ready = 0).
- in_ready is a combinational decode of state == IDLE.

## Timing

- Reset (rst_n low, asynchronous): state = IDLE, out_valid = 0, result = 0, acc = 0, bit counter = 0, pixel register = 0. in_ready reads 1 while held in reset.
- Accept at edge k. Planes are processed at edges k+1..k+PIX_W.
- out_valid is visible from the cycle after edge k+PIX_W. Latency from accept edge to out_valid is PIX_W edges.
- Output handshake at edge m (out_valid && out_ready): out_valid = 0 and in_ready = 1 in the cycle after m.
- There is no same-cycle re-accept.
- With out_ready tied high, the steady-state period is PIX_W+2 cycles per column (10 for defaults).
- out_ready held low: DONE persists indefinitely, and result and out_valid do not change.
- rst_n asserted mid-RUN or mid-DONE: immediately return to reset values. The partial column is discarded and no out_valid is produced for it.
- in_valid dropping after the accept edge has no effect.

## Test plan

- Unsigned, all pixels 255, out_ready=1 -> result = 1020 (weight sum 4 x 255); out_valid rises exactly 8 cycles after the accept edge.
- Unsigned, pixel5=255 and the rest 0 -> result = -1530. Pixels with positive weights = 255 and negative = 0 -> 4080. The reverse -> -3060.
- SIGNED_PIX=1: all pixels 0x80 -> -512. Positive-weight pixels 0x80 and negative-weight pixels 0x7F -> -3572. Pixel0=0xFF alone -> -1.
- Backpressure: hold out_ready=0 for 20 cycles -> result and out_valid stay stable and in_ready stays 0; a new in_valid with different data does not alter result. Release -> handshake, then in_ready=1 on the next cycle.
- Back-to-back: 50 random columns with in_valid always high and out_ready randomly toggled -> every result matches the reference dot product, no column is dropped or duplicated, and the period is 10 cycles when out_ready=1.
- Reset at RUN cycle 4 -> out_valid stays 0, result=0, in_ready=1. The next column after reset release produces a correct result.
